// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead add/sub: STAGES-cycle latency, 1/cycle; CLA_SATURATE_EN adds signed saturation.
// Backpressure: the whole pipe holds while oValid & ~iReady; oReady = ~oValid | iReady.
module cla_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarryIn,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry,
  output logic             oOverflow
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;

  // Returns {carry into segment MSB, segment carry-out, segment sum}.
  function automatic logic [SEG+1:0] claSeg(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                            input logic cin);
    logic [SEG-1:0]  g, p, s;
    logic [SEG:0]    c;
    logic [NGRP-1:0] gg, gp;
    logic [NGRP:0]   gc;
    logic            term;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    // Group carries as flat sum-of-products over group G/P, so no carry ripples between groups.
    gc    = '0;
    gc[0] = cin;
    for (int j = 1; j <= NGRP; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    c = '0;
    for (int j = 0; j < NGRP; j++) begin
      c[j*BLOCK] = gc[j];
      for (int i = 1; i < BLOCK; i++)
        c[j*BLOCK+i] = g[j*BLOCK+i-1] | (p[j*BLOCK+i-1] & c[j*BLOCK+i-1]);
    end
    c[SEG] = gc[NGRP];
    s = p ^ c[SEG-1:0];
    return {c[SEG-1], c[SEG], s};
  endfunction

  logic             stV [STAGES];
  logic [WIDTH-1:0] stA [STAGES];
  logic [WIDTH-1:0] stB [STAGES];
  logic [WIDTH-1:0] stS [STAGES];
  logic             stC [STAGES];
  logic             stOvf;

  logic [WIDTH-1:0] inA [STAGES];
  logic [WIDTH-1:0] inB [STAGES];
  logic [WIDTH-1:0] inS [STAGES];
  logic             inC [STAGES];
  logic [WIDTH-1:0] nxS [STAGES];
  logic             nxC [STAGES];
  logic [SEG+1:0]   segRes [STAGES];
  logic             ovfRaw;
  logic [WIDTH-1:0] finalSum;
  logic             adv;

  assign adv       = ~oValid | iReady;
  assign oReady    = adv;
  assign oValid    = stV[STAGES-1];
  assign oSum      = stS[STAGES-1];
  assign oCarry    = stC[STAGES-1];
  assign oOverflow = stOvf;

  always_comb begin
    inA[0] = iA;
    inB[0] = iSub ? ~iB : iB;
    inC[0] = iSub | iCarryIn;
    inS[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      inA[k] = stA[k-1];
      inB[k] = stB[k-1];
      inC[k] = stC[k-1];
      inS[k] = stS[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      segRes[k]            = claSeg(inA[k][k*SEG +: SEG], inB[k][k*SEG +: SEG], inC[k]);
      nxS[k]               = inS[k];
      nxS[k][k*SEG +: SEG] = segRes[k][SEG-1:0];
      nxC[k]               = segRes[k][SEG];
    end
    ovfRaw   = segRes[STAGES-1][SEG+1] ^ segRes[STAGES-1][SEG];
    finalSum = nxS[STAGES-1];
`ifdef CLA_SATURATE_EN
    if (ovfRaw)
      finalSum = inA[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // Data registers load only behind a valid token; bubbles move just the valid bit.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int k = 0; k < STAGES; k++) begin
        stV[k] <= 1'b0;
        stA[k] <= '0;
        stB[k] <= '0;
        stS[k] <= '0;
        stC[k] <= 1'b0;
      end
      stOvf <= 1'b0;
    end else if (adv) begin
      stV[0] <= iValid;
      for (int k = 1; k < STAGES; k++) stV[k] <= stV[k-1];
      for (int k = 0; k < STAGES; k++) begin
        if ((k == 0) ? iValid : stV[(k == 0) ? 0 : k-1]) begin
          stA[k] <= inA[k];
          stB[k] <= inB[k];
          stC[k] <= nxC[k];
          stS[k] <= (k == STAGES - 1) ? finalSum : nxS[k];
        end
      end
      if ((STAGES == 1) ? iValid : stV[(STAGES > 1) ? STAGES-2 : 0]) stOvf <= ovfRaw;
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed 8-bit cases plus randomized 32/4 and 16/1 runs against an arithmetic model.
module tb_cla_adder_pipe;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  a8, b8, sum8;
  logic        cin8, sub8, vIn8, rdy8, vOut8, rIn8, c8, ovf8;
  logic [31:0] a32, b32, sum32;
  logic        cin32, sub32, vIn32, rdy32, vOut32, rIn32, c32, ovf32;
  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, vIn16, rdy16, vOut16, rIn16, c16, ovf16;

  cla_adder_pipe #(.WIDTH(8), .BLOCK(4), .STAGES(2)) dut8 (
    .iClk(clk), .iRstN(rstN), .iValid(vIn8), .oReady(rdy8), .iA(a8), .iB(b8),
    .iCarryIn(cin8), .iSub(sub8), .oValid(vOut8), .iReady(rIn8), .oSum(sum8),
    .oCarry(c8), .oOverflow(ovf8));
  cla_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(4)) dut32 (
    .iClk(clk), .iRstN(rstN), .iValid(vIn32), .oReady(rdy32), .iA(a32), .iB(b32),
    .iCarryIn(cin32), .iSub(sub32), .oValid(vOut32), .iReady(rIn32), .oSum(sum32),
    .oCarry(c32), .oOverflow(ovf32));
  cla_adder_pipe #(.WIDTH(16), .BLOCK(4), .STAGES(1)) dut16 (
    .iClk(clk), .iRstN(rstN), .iValid(vIn16), .oReady(rdy16), .iA(a16), .iB(b16),
    .iCarryIn(cin16), .iSub(sub16), .oValid(vOut16), .iReady(rIn16), .oSum(sum16),
    .oCarry(c16), .oOverflow(ovf16));

  logic [33:0] q32[$];
  logic [33:0] q16[$];
  logic [33:0] q8[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, carry, sum[31:0]} from plain integer arithmetic.
  function automatic logic [33:0] refModel(input int w, input longint unsigned a, input longint unsigned b,
                                           input bit cin, input bit sub);
    longint unsigned mask, half, raw, sum;
    longint sa, sb, sres, hs;
    bit c, o;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    hs   = longint'(half);
    sa   = (a & half) != 0 ? longint'(a) - 2 * hs : longint'(a);
    sb   = (b & half) != 0 ? longint'(b) - 2 * hs : longint'(b);
    if (sub) begin
      raw  = a - b;
      c    = (a >= b);
      sres = sa - sb;
    end else begin
      raw  = a + b + longint'(cin);
      c    = ((raw >> w) & 64'd1) != 0;
      sres = sa + sb + longint'(cin);
    end
    o   = (sres > hs - 1) || (sres < -hs);
    sum = raw & mask;
`ifdef CLA_SATURATE_EN
    if (o) sum = ((a & half) != 0) ? half : half - 64'd1;
`endif
    return {o, c, sum[31:0]};
  endfunction

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [7:0] eSum, input logic eC, input logic eO);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; vIn8 = 1'b1; rIn8 = 1'b1;
    @(negedge clk);
    vIn8 = 1'b0;
    chk({tag, " early"}, vOut8, 1'b0);
    @(negedge clk);
    chk({tag, " valid"}, vOut8, 1'b1);
    chk({tag, " sum"}, sum8, eSum);
    chk({tag, " carry"}, c8, eC);
    chk({tag, " ovf"}, ovf8, eO);
    @(negedge clk);
    chk({tag, " one-cycle"}, vOut8, 1'b0);
  endtask

  task automatic stepRandom(input bit drive);
    logic [33:0] e;
    @(negedge clk);
    vIn32 = drive && ($urandom_range(0, 3) != 0);
    a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
    rIn32 = !drive || ($urandom_range(0, 3) != 0);
    vIn16 = drive && ($urandom_range(0, 3) != 0);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    rIn16 = !drive || ($urandom_range(0, 3) != 0);
    #1;
    if (vOut32 && rIn32) begin
      chk("rnd32 spurious", q32.size() == 0, 1'b0);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("rnd32 carry/sum", {c32, sum32}, e[32:0]);
        chk("rnd32 ovf", ovf32, e[33]);
      end
    end
    if (vIn32 && rdy32) q32.push_back(refModel(32, a32, b32, cin32, sub32));
    if (vOut16 && rIn16) begin
      chk("rnd16 spurious", q16.size() == 0, 1'b0);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("rnd16 carry/sum", {c16, sum16}, {e[32], e[15:0]});
        chk("rnd16 ovf", ovf16, e[33]);
      end
    end
    if (vIn16 && rdy16) q16.push_back(refModel(16, a16, b16, cin16, sub16));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ba [4];
    logic [7:0]  bb [4];
    logic [33:0] e;
    int sent, got, held;

    {a8, b8, cin8, sub8, vIn8, rIn8} = '0;
    {a32, b32, cin32, sub32, vIn32, rIn32} = '0;
    {a16, b16, cin16, sub16, vIn16, rIn16} = '0;

    // Reset state
    #2;
    chk("reset valid", vOut8, 1'b0);
    chk("reset sum", sum8, 8'h00);
    chk("reset carry", c8, 1'b0);
    chk("reset ovf", ovf8, 1'b0);
    #10 rstN = 1'b1;
    @(negedge clk);
    chk("reset ready", rdy8, 1'b1);

    // Directed arithmetic
    run8("add", 8'h3C, 8'h0A, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    run8("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("sub", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
`ifdef CLA_SATURATE_EN
    run8("ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);
`else
    run8("ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`endif

    // Backpressure: 4 back-to-back inputs, 3 stalled output cycles
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom);
      bb[i] = 8'($urandom);
    end
    sent = 0; got = 0; held = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      vIn8 = (sent < 4);
      if (sent < 4) begin
        a8 = ba[sent]; b8 = bb[sent]; cin8 = sent[0]; sub8 = sent[1];
      end
      rIn8 = (held >= 3);
      #1;
      if (vOut8 && !rIn8) begin
        chk("bp ready low", rdy8, 1'b0);
        chk("bp held sum", sum8, q8[0][7:0]);
        held++;
      end else if (vOut8 && rIn8) begin
        e = q8.pop_front();
        chk("bp order sum", {c8, sum8}, {e[32], e[7:0]});
        got++;
      end
      if (vIn8 && rdy8) begin
        q8.push_back(refModel(8, ba[sent], bb[sent], sent[0], sent[1]));
        sent++;
      end
    end
    chk("bp all results", got, 4);
    @(negedge clk);
    vIn8 = 1'b0;
    #1;
    chk("bp no duplicate", vOut8, 1'b0);

    // Reset mid-flight
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; vIn8 = 1'b1; rIn8 = 1'b1;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44;
    @(negedge clk);
    vIn8 = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("rst-mid valid", vOut8, 1'b0);
    chk("rst-mid sum", sum8, 8'h00);
    #1 rstN = 1'b1;
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h05; cin8 = 1'b1; vIn8 = 1'b1;
    @(negedge clk);
    vIn8 = 1'b0;
    chk("rst-mid bubble", vOut8, 1'b0);
    @(negedge clk);
    chk("rst-mid next valid", vOut8, 1'b1);
    chk("rst-mid next sum", sum8, 8'h26);

    // Randomized runs on the 32/4 and 16/1 instances
    for (int cyc = 0; cyc < 1400; cyc++) stepRandom(1'b1);
    for (int cyc = 0; cyc < 10; cyc++) stepRandom(1'b0);
    chk("rnd32 drained", q32.size(), 0);
    chk("rnd16 drained", q16.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
